decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder.sv | 143 ++++++++++++++
 tb/tb_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// Instruction decode stage: registered control flags, ALU op, branch/jump target, forwarded operands.
// Optional operand forwarding is enabled by defining DECODER_FWD_EN.
module decoder #(
   parameter TAG = "1"
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Instr,
   input  logic [31:0] Instr_PC_Plus4,
   input  logic [31:0] RegValA,
   input  logic [31:0] RegValB,
   input  logic [31:0] ALUVal,
   input  logic [31:0] MEMVal,
   input  logic [31:0] WBVal,
   input  logic [1:0]  SelA,
   input  logic [1:0]  SelB,
   output logic        Link,
   output logic        RegDest,
   output logic        Jump,
   output logic        Branch,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic        JumpRegister,
   output logic        SignOrZero,
   output logic        Syscall,
   output logic [5:0]  ALUControl,
   output logic [31:0] NextAddr,
   output logic [31:0] FwdA,
   output logic [31:0] FwdB
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic        is_r, is_regimm, is_imm, is_load, is_store, known, link_branch;
   logic        d_link, d_regdest, d_jump, d_branch, d_memread, d_memwrite;
   logic        d_alusrc, d_regwrite, d_jr, d_soz, d_sys;
   logic [5:0]  d_aluc;
   logic [31:0] d_next, d_fwd_a, d_fwd_b;
   logic [31:0] imm_ext;
   logic        unused_tag;

   assign opcode     = Instr[31:26];
   assign rt         = Instr[20:16];
   assign funct      = Instr[5:0];
   assign unused_tag = ^TAG;

`ifdef DECODER_FWD_EN
   always_comb begin
      d_fwd_a = RegValA;
      d_fwd_b = RegValB;
      case (SelA)
         2'd1:    d_fwd_a = ALUVal;
         2'd2:    d_fwd_a = MEMVal;
         2'd3:    d_fwd_a = WBVal;
         default: d_fwd_a = RegValA;
      endcase
      case (SelB)
         2'd1:    d_fwd_b = ALUVal;
         2'd2:    d_fwd_b = MEMVal;
         2'd3:    d_fwd_b = WBVal;
         default: d_fwd_b = RegValB;
      endcase
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{SelA, SelB, ALUVal, MEMVal, WBVal};
   assign d_fwd_a    = RegValA;
   assign d_fwd_b    = RegValB;
`endif

   always_comb begin
      is_r        = (opcode == 6'h00);
      is_regimm   = (opcode == 6'h01);
      is_imm      = (opcode inside {[6'h08:6'h0F]});
      is_load     = (opcode inside {[6'h20:6'h26], 6'h30});
      is_store    = (opcode inside {[6'h28:6'h2B], 6'h2E, 6'h38});
      known       = (opcode inside {[6'h00:6'h0F]}) || is_load || is_store;
      link_branch = is_regimm && (rt == 5'h10 || rt == 5'h11);

      // Every flag is qualified by a recognised opcode, so unknown opcodes decode to all-zero flags.
      d_jr       = is_r && (funct == 6'h08 || funct == 6'h09);
      d_jump     = (opcode == 6'h02) || (opcode == 6'h03) || d_jr;
      d_branch   = is_regimm || (opcode inside {[6'h04:6'h07]});
      d_link     = (opcode == 6'h03) || (is_r && funct == 6'h09) || link_branch;
      d_regdest  = is_r;
      d_alusrc   = is_imm || is_load || is_store;
      d_memread  = is_load;
      d_memwrite = is_store;
      d_regwrite = (is_r && !(funct inside {6'h08, 6'h0C, 6'h11, 6'h13, [6'h18:6'h1B]}))
                   || is_imm || is_load || (opcode == 6'h38) || (opcode == 6'h03) || link_branch;
      d_soz      = known && !(opcode inside {[6'h0C:6'h0E]});
      d_sys      = is_r && (funct == 6'h0C);
      d_aluc     = is_r ? funct : opcode;

      imm_ext = {{14{Instr[15]}}, Instr[15:0], 2'b00};
      if (d_jr)
         d_next = d_fwd_a;
      else if (d_jump)
         d_next = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};
      else
         d_next = Instr_PC_Plus4 + imm_ext;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Link         <= 1'b0;
         RegDest      <= 1'b0;
         Jump         <= 1'b0;
         Branch       <= 1'b0;
         MemRead      <= 1'b0;
         MemWrite     <= 1'b0;
         ALUSrc       <= 1'b0;
         RegWrite     <= 1'b0;
         JumpRegister <= 1'b0;
         SignOrZero   <= 1'b0;
         Syscall      <= 1'b0;
         ALUControl   <= '0;
         NextAddr     <= '0;
         FwdA         <= '0;
         FwdB         <= '0;
      end else begin
         Link         <= d_link;
         RegDest      <= d_regdest;
         Jump         <= d_jump;
         Branch       <= d_branch;
         MemRead      <= d_memread;
         MemWrite     <= d_memwrite;
         ALUSrc       <= d_alusrc;
         RegWrite     <= d_regwrite;
         JumpRegister <= d_jr;
         SignOrZero   <= d_soz;
         Syscall      <= d_sys;
         ALUControl   <= d_aluc;
         NextAddr     <= d_next;
         FwdA         <= d_fwd_a;
         FwdB         <= d_fwd_b;
      end
   end

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed cases plus randomized instructions against a reference model.
module tb_decoder;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] Instr, Instr_PC_Plus4, RegValA, RegValB, ALUVal, MEMVal, WBVal;
   logic [1:0]  SelA, SelB;
   logic        Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite;
   logic        JumpRegister, SignOrZero, Syscall;
   logic [5:0]  ALUControl;
   logic [31:0] NextAddr, FwdA, FwdB;

   int unsigned tests = 0;
   int unsigned fails = 0;

   decoder #(.TAG("tb")) dut (
      .CLK(CLK), .RESET(RESET), .Instr(Instr), .Instr_PC_Plus4(Instr_PC_Plus4),
      .RegValA(RegValA), .RegValB(RegValB), .ALUVal(ALUVal), .MEMVal(MEMVal), .WBVal(WBVal),
      .SelA(SelA), .SelB(SelB), .Link(Link), .RegDest(RegDest), .Jump(Jump), .Branch(Branch),
      .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
      .JumpRegister(JumpRegister), .SignOrZero(SignOrZero), .Syscall(Syscall),
      .ALUControl(ALUControl), .NextAddr(NextAddr), .FwdA(FwdA), .FwdB(FwdB)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      bit        link, regdest, jump, branch, memrd, memwr, alusrc, regwr, jr, soz, sys;
      bit [5:0]  aluc;
      bit [31:0] na, fa, fb;
   } exp_t;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r, a, m, w);
      logic [31:0] src [4];
      src = '{r, a, m, w};
`ifdef DECODER_FWD_EN
      return src[sel];
`else
      return src[0];
`endif
   endfunction

   // Reference decode written from the opcode/funct tables.
   function automatic exp_t model(input logic [31:0] ins, pc4, ra, rb, av, mv, wv,
                                  input logic [1:0] sa, sb);
      exp_t e;
      int op, fn, rtv;
      bit r, load, store, imm, recog, lbr;
      op = int'(ins[31:26]); fn = int'(ins[5:0]); rtv = int'(ins[20:16]);
      r     = (op == 0);
      load  = (op >= 32 && op <= 38) || op == 48;
      store = (op >= 40 && op <= 43) || op == 46 || op == 56;
      imm   = (op >= 8 && op <= 15);
      recog = (op <= 15) || load || store;
      lbr   = (op == 1) && (rtv == 16 || rtv == 17);
      e = '0;
      e.jr      = r && (fn == 8 || fn == 9);
      e.jump    = op == 2 || op == 3 || e.jr;
      e.branch  = op == 1 || (op >= 4 && op <= 7);
      e.link    = op == 3 || (r && fn == 9) || lbr;
      e.regdest = r;
      e.alusrc  = imm || load || store;
      e.memrd   = load;
      e.memwr   = store;
      e.regwr   = (r && !(fn == 8 || fn == 12 || fn == 17 || fn == 19 || (fn >= 24 && fn <= 27)))
                  || imm || load || op == 56 || op == 3 || lbr;
      e.soz     = recog && !(op >= 12 && op <= 14);
      e.sys     = r && fn == 12;
      e.aluc    = r ? ins[5:0] : ins[31:26];
      e.fa      = pick(sa, ra, av, mv, wv);
      e.fb      = pick(sb, rb, av, mv, wv);
      if (e.jr)        e.na = e.fa;
      else if (e.jump) e.na = (pc4 & 32'hF000_0000) | (32'(ins[25:0]) * 4);
      else             e.na = 32'(longint'(pc4) + longint'($signed(ins[15:0])) * 4);
      return e;
   endfunction

   task automatic check_outputs(input exp_t e);
      check("Link",         32'(Link),         32'(e.link));
      check("RegDest",      32'(RegDest),      32'(e.regdest));
      check("Jump",         32'(Jump),         32'(e.jump));
      check("Branch",       32'(Branch),       32'(e.branch));
      check("MemRead",      32'(MemRead),      32'(e.memrd));
      check("MemWrite",     32'(MemWrite),     32'(e.memwr));
      check("ALUSrc",       32'(ALUSrc),       32'(e.alusrc));
      check("RegWrite",     32'(RegWrite),     32'(e.regwr));
      check("JumpRegister", 32'(JumpRegister), 32'(e.jr));
      check("SignOrZero",   32'(SignOrZero),   32'(e.soz));
      check("Syscall",      32'(Syscall),      32'(e.sys));
      check("ALUControl",   32'(ALUControl),   32'(e.aluc));
      check("NextAddr",     NextAddr,          e.na);
      check("FwdA",         FwdA,              e.fa);
      check("FwdB",         FwdB,              e.fb);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_flags"}, 32'({Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc,
                                  RegWrite, JumpRegister, SignOrZero, Syscall, ALUControl}), 32'h0);
      check({tag, "_next"}, NextAddr, 32'h0);
      check({tag, "_fwda"}, FwdA, 32'h0);
      check({tag, "_fwdb"}, FwdB, 32'h0);
   endtask

   // Drive one instruction, clock it in, compare against the model.
   task automatic apply(input logic [31:0] ins, pc4, ra, rb, av, mv, wv, input logic [1:0] sa, sb);
      exp_t e;
      Instr = ins; Instr_PC_Plus4 = pc4; RegValA = ra; RegValB = rb;
      ALUVal = av; MEMVal = mv; WBVal = wv; SelA = sa; SelB = sb;
      e = model(ins, pc4, ra, rb, av, mv, wv, sa, sb);
      @(posedge CLK);
      #1;
      check_outputs(e);
   endtask

   int unsigned known_ops [$] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                 6'h20, 6'h21, 6'h23, 6'h24, 6'h26, 6'h28, 6'h2B, 6'h2E,
                                 6'h30, 6'h38};

   initial begin
      logic [31:0] ins;
      logic [5:0]  op;
      RESET = 1'b0;
      Instr = 32'h0000_0020; Instr_PC_Plus4 = 32'h1234; RegValA = 32'h55; RegValB = 32'h66;
      ALUVal = '0; MEMVal = '0; WBVal = '0; SelA = '0; SelB = '0;
      #17;
      check_zero("reset");
      @(negedge CLK);
      RESET = 1'b1;

      // J 0x10
      apply(32'h0800_0010, 32'h4000_0004, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0);
      check("j_jump", 32'(Jump), 32'd1);
      check("j_next", NextAddr, 32'h4000_0040);
      check("j_regwrite", 32'(RegWrite), 32'd0);

      // BEQ with imm -1
      apply(32'h1000_FFFF, 32'h0000_0100, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0);
      check("beq_branch", 32'(Branch), 32'd1);
      check("beq_next", NextAddr, 32'h0000_00FC);

      // JALR with operand A forwarded from MEM
      apply(32'h0020_F809, 32'h0000_2000, 32'hAAAA, 32'hBBBB, 32'h7777, 32'h1234, 32'h9999, 2'd2, 2'd3);
      check("jalr_jr", 32'(JumpRegister), 32'd1);
      check("jalr_link", 32'(Link), 32'd1);
`ifdef DECODER_FWD_EN
      check("jalr_next", NextAddr, 32'h1234);
      check("jalr_fwda", FwdA, 32'h1234);
`else
      check("jalr_next", NextAddr, 32'hAAAA);
      check("jalr_fwda", FwdA, 32'hAAAA);
`endif

      apply(32'h0000_000C, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0);
      check("sys_syscall", 32'(Syscall), 32'd1);
      check("sys_aluc", 32'(ALUControl), 32'h0C);
      check("sys_regwrite", 32'(RegWrite), 32'd0);

      apply(32'h3422_00FF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0);
      check("ori_soz", 32'(SignOrZero), 32'd0);
      check("ori_alusrc", 32'(ALUSrc), 32'd1);

      // Unrecognised opcode
      apply(32'hFC00_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0);
      check("unk_aluc", 32'(ALUControl), 32'h3F);
      check("unk_soz", 32'(SignOrZero), 32'd0);

      apply(32'h8C22_0004, 32'h100, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0);
      check("lw_memread", 32'(MemRead), 32'd1);
      apply(32'hAC22_0004, 32'h100, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0);
      check("sw_memwrite", 32'(MemWrite), 32'd1);

      // Asynchronous reset between clock edges
      #2 RESET = 1'b0;
      #1 check_zero("async_rst");
      @(negedge CLK);
      RESET = 1'b1;

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 5))
            0:       op = 6'h00;
            1:       op = 6'($urandom);
            default: op = 6'(known_ops[$urandom_range(0, known_ops.size() - 1)]);
         endcase
         ins = {op, 26'($urandom)};
         if (op == 6'h01 && $urandom_range(0, 1) == 1)
            ins[20:16] = 5'h10 | 5'($urandom_range(0, 1));
         apply(ins, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               2'($urandom), 2'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
